// File: rtl/pipe_stage_fifo_if.sv
// Handshake bundle between the ID stage (master) and the ID->EX buffering stage (slave).
interface pipe_stage_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);
  logic              flush;
  logic              hold;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, hold, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, hold, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// ID->EX pipeline buffer: circular FIFO with flush, hold and registered-only output path.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // in_ready looks only at occupancy so no comb path from downstream controls
  always_comb begin
    w_in_ready  = (r_count < CNT_W'(DEPTH));
    w_out_valid = (r_count != '0);
    w_push      = bus.in_valid & w_in_ready & ~bus.flush;
    w_pop       = w_out_valid & bus.out_ready & ~bus.hold & ~bus.flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; stale entries are masked on the output
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_out_valid;
    bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    bus.count     = r_count;
  end
endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits (the ID->EX bundle packed into one bus); legal range 1..256.
REQ-002 Parameter DEPTH, default 2: number of buffered entries; power of two, 2..16.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1: occupancy counter width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 flush  input  1  branch interception; discards all buffered entries.
REQ-007 hold  input  1  downstream stall; freezes the output entry.
REQ-008 in_valid  input  1  upstream offers in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ready  output  1  buffer can accept a push this cycle.
REQ-011 out_valid  output  1  out_data holds a valid entry.
REQ-012 out_data  output  DATA_W  oldest entry; all-zero (bubble) when out_valid=0.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 count  output  CNT_W  current number of valid entries, 0..DEPTH.

Function
REQ-015 The block SHALL be a circular FIFO with write pointer, read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready, hold or flush.
REQ-017 A push SHALL occur when in_valid & in_ready & !flush; in_data is written at wr_ptr, wr_ptr increments.
REQ-018 A pop SHALL occur when out_valid & out_ready & !hold & !flush; rd_ptr increments.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL be storage[rd_ptr] when out_valid=1, else zero.
REQ-020 No combinational bypass: data pushed in cycle N SHALL first appear on out_data in cycle N+1 (minimum latency one clock).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 When full (count=DEPTH), in_ready=0; in_valid is ignored with no state change.
REQ-023 When empty, out_ready is ignored; count never underflows.
REQ-024 flush SHALL take priority over push, pop and hold: next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0, out_data=0; the same-cycle in_data is dropped.
REQ-025 hold=1 (without flush) SHALL freeze rd_ptr and out_data; pushes still proceed while not full.
REQ-026 count SHALL update as count + push - pop each cycle, saturating only by construction (never exceeds DEPTH).
REQ-027 Storage contents of invalid entries need not be cleared, but SHALL never be visible on out_data.
REQ-028 Behaviour SHALL be identical for every legal DATA_W/DEPTH; no entry payload bit is interpreted.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force count=0, pointers=0, out_valid=0, out_data=0, in_ready=1.
REQ-030 Storage array SHALL NOT require reset.
REQ-031 Deassertion of rst is synchronised externally; the first push is accepted on the first rising edge with rst=1.
REQ-032 Assertion of rst mid-operation SHALL discard all entries, including a push in that cycle.

Verification
REQ-033 DATA_W=8, DEPTH=4: push 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=0 -> count 1,2,3,4; in_ready=0 after 4th; 5th push 0x55 ignored; then out_ready=1 yields 0x11..0x44 in order, count returns to 0.
REQ-034 Push 0xA5 in cycle N with FIFO empty, out_ready=1 -> out_valid=0 in cycle N, out_valid=1 with out_data=0xA5 in N+1, popped at N+1, empty in N+2.
REQ-035 count=2, in_valid=1 with 0x77, out_ready=1, flush=1 same cycle -> next cycle count=0, out_valid=0, out_data=0x00; 0x77 never emerges.
REQ-036 count=3, hold=1, out_ready=1, push 0x99 -> count=4, out_data unchanged for all hold cycles; hold=0 resumes pops in original order ending with 0x99.
REQ-037 Continuous push+pop for 10 cycles from count=1 -> count stays 1, pointers wrap past 3 -> 0 twice, output order matches input order.
REQ-038 rst=0 asserted between clock edges with count=3 -> out_valid=0, count=0, in_ready=1 before the next rising edge.
